// File: rtl/uart_pkg.sv
// Shared types for the UART transmit-side scheduler.
package uart_pkg;
    typedef enum logic [1:0] {IDLE, SEND, FLUSH} tx_sched_state_t;
    typedef enum logic {PRIO_A, PRIO_B} prio_t;
endpackage

// File: rtl/fifo_sync.sv
// Synchronous FIFO with a registered read port: dout changes only on a pop.
module fifo_sync #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int ADDR_BITS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam logic [ADDR_BITS:0] DEPTH_CNT = (ADDR_BITS+1)'(DEPTH);

    // One extra pointer bit distinguishes full from empty.
    logic [ADDR_BITS:0]              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DEPTH-1:0][WIDTH-1:0]     mem_q, mem_d;
    logic [WIDTH-1:0]                dout_q, dout_d;

    assign full  = (wr_ptr_q - rd_ptr_q) == DEPTH_CNT;
    assign empty = wr_ptr_q == rd_ptr_q;
    assign dout  = dout_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        dout_d   = dout_q;
        if (wr_en && !full) begin
            mem_d[wr_ptr_q[ADDR_BITS-1:0]] = din;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_en && !empty) begin
            dout_d   = mem_q[rd_ptr_q[ADDR_BITS-1:0]];
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            dout_q   <= dout_d;
        end
    end

    always_ff @(posedge clk) mem_q <= mem_d;
endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin merge of two byte producers into one TX FIFO, drained to the
// UART transmitter through a valid/ready handshake with flush support.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int ADDR_BITS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    input  logic             en,
    input  logic             flush,
    output logic             tx_valid,
    output logic [WIDTH-1:0] tx_data,
    input  logic             tx_ready,
    output logic             busy
);
    tx_sched_state_t  state_q, state_d;
    prio_t            prio_q, prio_d;
    logic             flush_pend_q, flush_pend_d;
    logic             tx_valid_q, tx_valid_d;
    logic             full, empty, wr_en, rd_en, fifo_rst, flush_blk;
    logic             grant_a, grant_b;
    logic [WIDTH-1:0] din;

    assign flush_blk = flush | flush_pend_q | (state_q == FLUSH);
    assign grant_a   = a_valid & (!b_valid | (prio_q == PRIO_A));
    assign grant_b   = b_valid & !grant_a;
    assign a_ready   = grant_a & !full & !flush_blk & !rst;
    assign b_ready   = grant_b & !full & !flush_blk & !rst;
    assign wr_en     = (a_ready & a_valid) | (b_ready & b_valid);
    assign din       = grant_a ? a_data : b_data;
    // A pending flush wins over a pop so queued bytes are never sent after it.
    assign rd_en     = (state_q == IDLE) & !flush & !flush_pend_q & en & !empty;
    assign fifo_rst  = rst | (state_q == FLUSH);
    assign tx_valid  = tx_valid_q;
    assign busy      = (state_q != IDLE) | !empty;

    fifo_sync #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_BITS(ADDR_BITS)) u_fifo (
        .clk   (clk),
        .rst   (fifo_rst),
        .wr_en (wr_en),
        .din   (din),
        .rd_en (rd_en),
        .dout  (tx_data),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        prio_d       = prio_q;
        state_d      = state_q;
        flush_pend_d = flush_pend_q;
        if (wr_en) prio_d = grant_a ? PRIO_B : PRIO_A;
        case (state_q)
            IDLE: begin
                if (flush || flush_pend_q) state_d = FLUSH;
                else if (rd_en)            state_d = SEND;
            end
            SEND: begin
                if (flush) flush_pend_d = 1'b1;
                if (tx_ready) state_d = (flush || flush_pend_q) ? FLUSH : IDLE;
            end
            FLUSH: begin
                flush_pend_d = 1'b0;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
        tx_valid_d = (state_d == SEND);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            prio_q       <= PRIO_A;
            flush_pend_q <= 1'b0;
            tx_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            prio_q       <= prio_d;
            flush_pend_q <= flush_pend_d;
            tx_valid_q   <= tx_valid_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: directed vector table, hand sequences and random
// traffic, all compared against a queue-based behavioural model.
module tb_uart_tx_sched;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst, a_valid, b_valid, en, flush, tx_ready;
    logic [7:0] a_data, b_data, tx_data;
    logic       a_ready, b_ready, tx_valid, busy;

    always #5 clk = ~clk;

    uart_tx_sched #(.WIDTH(8), .DEPTH(4), .ADDR_BITS(2)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
        .en(en), .flush(flush),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .busy(busy)
    );

    typedef struct {
        logic       rst, av; logic [7:0] ad;
        logic       bv;      logic [7:0] bd;
        logic       en, fl, tr;
        logic       ea, eb, etv; logic [7:0] etd; logic ebusy;
    } vec_t;

    int         n_chk = 0, n_fail = 0, acc_cnt = 0;
    logic [7:0] mq[$];
    logic [7:0] got[$];
    logic [7:0] m_last;
    bit         m_hold, m_flushing, m_pend, m_turn_b;
    bit         model_on = 0, auto_inc = 0, row_on = 0;
    vec_t       cur;
    vec_t       tbl[$];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: compare at negedge, advance the model at posedge.
    task automatic tick();
        bit blk, ga, gb, ea, eb;
        @(negedge clk);
        blk = flush | m_pend | m_flushing;
        ga  = a_valid & (!b_valid | !m_turn_b);
        gb  = b_valid & !ga;
        ea  = ga & (mq.size() < D) & !blk & !rst;
        eb  = gb & (mq.size() < D) & !blk & !rst;
        if (model_on) begin
            check("m_a_ready",  8'(a_ready),  8'(ea));
            check("m_b_ready",  8'(b_ready),  8'(eb));
            check("m_tx_valid", 8'(tx_valid), 8'(m_hold));
            check("m_tx_data",  tx_data,      m_last);
            check("m_busy",     8'(busy),     8'(m_hold | m_flushing | (mq.size() != 0)));
        end
        if (row_on) begin
            check("v_a_ready",  8'(a_ready),  8'(cur.ea));
            check("v_b_ready",  8'(b_ready),  8'(cur.eb));
            check("v_tx_valid", 8'(tx_valid), 8'(cur.etv));
            check("v_tx_data",  tx_data,      cur.etd);
            check("v_busy",     8'(busy),     8'(cur.ebusy));
        end
        if (tx_valid && tx_ready) got.push_back(tx_data);
        if ((a_ready && a_valid) || (b_ready && b_valid)) acc_cnt++;
        @(posedge clk);
        if (rst) begin
            mq.delete(); m_hold = 0; m_flushing = 0; m_pend = 0; m_turn_b = 0; m_last = 8'h00;
        end else begin
            if (m_flushing) begin
                mq.delete(); m_last = 8'h00; m_flushing = 0; m_pend = 0;
            end else if (m_hold) begin
                if (flush) m_pend = 1;
                if (tx_ready) begin
                    m_hold = 0;
                    if (flush || m_pend) m_flushing = 1;
                end
            end else if (flush || m_pend) begin
                m_flushing = 1;
            end else if (en && mq.size() > 0) begin
                m_last = mq.pop_front();
                m_hold = 1;
            end
            if (ea) begin mq.push_back(a_data); m_turn_b = 1; end
            else if (eb) begin mq.push_back(b_data); m_turn_b = 0; end
        end
        #1;
        if (auto_inc) begin
            if (ea) a_data = a_data + 8'h01;
            if (eb) b_data = b_data + 8'h01;
        end
    endtask

    task automatic idle_inputs();
        rst = 0; a_valid = 0; b_valid = 0; flush = 0; tx_ready = 0; en = 1; auto_inc = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1; tick(); rst = 0;
        acc_cnt = 0; got.delete();
    endtask

    task automatic add(input logic r, av, input logic [7:0] ad, input logic e, fl, tr,
                       input logic ea, etv, input logic [7:0] etd, input logic eb_busy);
        tbl.push_back('{r, av, ad, 1'b0, 8'h00, e, fl, tr, ea, 1'b0, etv, etd, eb_busy});
    endtask

    logic [7:0] exp5[5];

    initial begin
        idle_inputs(); rst = 1; a_data = 0; b_data = 0;
        @(posedge clk); #1;
        tick();
        model_on = 1;

        // rst, av, ad, en, fl, tr | a_ready, tx_valid, tx_data, busy
        add(1, 1, 8'h41, 1, 0, 1,  0, 0, 8'h00, 0);
        add(0, 1, 8'h41, 1, 0, 1,  1, 0, 8'h00, 0);
        add(0, 0, 8'h00, 1, 0, 1,  0, 0, 8'h00, 1);
        add(0, 0, 8'h00, 1, 0, 1,  0, 1, 8'h41, 1);
        add(0, 0, 8'h00, 1, 0, 1,  0, 0, 8'h41, 0);
        add(0, 0, 8'h00, 1, 0, 1,  0, 0, 8'h41, 0);
        add(0, 1, 8'h01, 0, 0, 1,  1, 0, 8'h41, 0);
        add(0, 1, 8'h02, 0, 0, 1,  1, 0, 8'h41, 1);
        add(0, 1, 8'h03, 0, 0, 1,  1, 0, 8'h41, 1);
        add(0, 0, 8'h00, 0, 0, 1,  0, 0, 8'h41, 1);
        add(0, 0, 8'h00, 1, 0, 1,  0, 0, 8'h41, 1);
        add(0, 0, 8'h00, 1, 0, 1,  0, 1, 8'h01, 1);
        add(0, 0, 8'h00, 1, 0, 1,  0, 0, 8'h01, 1);
        add(0, 0, 8'h00, 1, 0, 1,  0, 1, 8'h02, 1);
        add(0, 0, 8'h00, 1, 0, 1,  0, 0, 8'h02, 1);
        add(0, 0, 8'h00, 1, 0, 1,  0, 1, 8'h03, 1);
        add(0, 0, 8'h00, 1, 0, 1,  0, 0, 8'h03, 0);
        row_on = 1;
        foreach (tbl[i]) begin
            cur = tbl[i];
            rst = cur.rst; a_valid = cur.av; a_data = cur.ad; b_valid = cur.bv; b_data = cur.bd;
            en = cur.en; flush = cur.fl; tx_ready = cur.tr;
            tick();
        end
        row_on = 0;

        // Contention: both producers stream while the transmitter stalls.
        do_reset();
        a_valid = 1; b_valid = 1; a_data = 8'h10; b_data = 8'h20; auto_inc = 1;
        repeat (10) tick();
        check("cont_accepted", 8'(acc_cnt), 8'd5);
        check("cont_a_blocked", 8'(a_ready), 8'd0);
        check("cont_b_blocked", 8'(b_ready), 8'd0);
        a_valid = 0; b_valid = 0; auto_inc = 0; tx_ready = 1;
        repeat (12) tick();
        exp5 = '{8'h10, 8'h20, 8'h11, 8'h21, 8'h12};
        check("cont_count", 8'(got.size()), 8'd5);
        for (int i = 0; i < 5 && i < got.size(); i++) check("cont_order", got[i], exp5[i]);

        // Flush while SEND holds 0x55 with three bytes queued behind it.
        do_reset();
        a_valid = 1; a_data = 8'h55; auto_inc = 1;
        repeat (4) tick();
        acc_cnt = 0; got.delete();
        flush = 1; tick(); flush = 0;
        repeat (2) tick();
        tx_ready = 1; tick(); tx_ready = 0;
        tick();
        check("flush_blocked", 8'(acc_cnt), 8'd0);
        check("flush_a_ready_after", 8'(a_ready), 8'd1);
        a_valid = 0; auto_inc = 0; tx_ready = 1;
        repeat (4) tick();
        check("flush_count", 8'(got.size()), 8'd1);
        if (got.size() > 0) check("flush_byte", got[0], 8'h55);
        check("flush_busy", 8'(busy), 8'd0);

        // Reset during SEND with two bytes queued.
        do_reset();
        a_valid = 1; a_data = 8'h30; auto_inc = 1;
        repeat (3) tick();
        a_valid = 0; auto_inc = 0;
        rst = 1; tick(); rst = 0;
        check("rst_tx_valid", 8'(tx_valid), 8'd0);
        check("rst_busy", 8'(busy), 8'd0);
        b_valid = 1; b_data = 8'h7E; tx_ready = 1; got.delete();
        tick(); b_valid = 0;
        tick();
        check("rst_b_tx_valid", 8'(tx_valid), 8'd1);
        check("rst_b_tx_data", tx_data, 8'h7E);
        repeat (3) tick();
        check("rst_b_count", 8'(got.size()), 8'd1);
        a_valid = 1; tx_ready = 0; tick(); a_valid = 0;
        rst = 1; tick(); rst = 0;
        a_valid = 1; b_valid = 1; #1;
        check("rst_prio_a", 8'(a_ready), 8'd1);
        check("rst_prio_b", 8'(b_ready), 8'd0);
        a_valid = 0; b_valid = 0;

        // Full boundary: one tx_ready pulse frees exactly one slot.
        do_reset();
        a_valid = 1; a_data = 8'h60; auto_inc = 1;
        repeat (7) tick();
        check("full_accepted", 8'(acc_cnt), 8'd5);
        check("full_a_blocked", 8'(a_ready), 8'd0);
        tx_ready = 1; tick(); tx_ready = 0;
        check("full_pop_cycle", 8'(a_ready), 8'd0);
        tick();
        check("full_after_pop", 8'(a_ready), 8'd1);
        tick();
        check("full_again", 8'(a_ready), 8'd0);
        check("full_accepted2", 8'(acc_cnt), 8'd6);
        idle_inputs();

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom % 200) == 0;
            a_valid  = $urandom % 2;
            b_valid  = $urandom % 2;
            a_data   = 8'($urandom);
            b_data   = 8'($urandom);
            en       = ($urandom % 8) != 0;
            flush    = ($urandom % 25) == 0;
            tx_ready = ($urandom % 3) != 0;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Transmit-side scheduler for the UART peripheral. It shares one synchronous TX FIFO between two byte producers, the CPU MMIO store path (A) and the RX-echo/debug path (B), using round-robin arbitration. It also sequences draining that FIFO into the UART transmitter over a valid/ready handshake. It sits between the MMIO register block and the transmitter and owns the FIFO instance.

## Interface

Parameters:
- WIDTH, 8, byte width
- DEPTH, 4, FIFO depth, power of 2
- ADDR_BITS, 2, log2(DEPTH)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- a_valid  in  1  producer A has a byte
- a_data  in  WIDTH  producer A byte
- a_ready  out  1  producer A byte accepted this cycle (when a_valid=1)
- b_valid  in  1  producer B has a byte
- b_data  in  WIDTH  producer B byte
- b_ready  out  1  producer B byte accepted this cycle
- en  in  1  drain enable
- flush  in  1  one-cycle pulse, discard all queued bytes
- tx_valid  out  1  byte offered to transmitter
- tx_data  out  WIDTH  byte to transmitter
- tx_ready  in  1  transmitter accepts
- busy  out  1  FSM not IDLE or FIFO not empty

## Operation

- **Arbitration**
  - prio bit, reset = A.
  - grant_a = a_valid & (!b_valid | prio==A); grant_b = b_valid & !grant_a.
  - x_ready = grant_x & !full & !flush_blk & !rst.
  - FIFO wr_en = (a_ready & a_valid) | (b_ready & b_valid). din is the granted data.
  - prio flips to the other producer only on a successful write.
  - A single requester is always granted, regardless of prio.
- **flush_blk** = flush | flush_pend | state==FLUSH.
- **Drain FSM**, states IDLE, SEND, FLUSH:
  - IDLE:
    - If flush | flush_pend: go to FLUSH.
    - Else if en & !empty: assert FIFO rd_en and go to SEND.
  - SEND:
    - tx_valid=1; tx_data = FIFO dout, which is registered and stable until the next pop.
    - On tx_ready: go to FLUSH if flush_pend | flush, else go to IDLE.
  - FLUSH:
    - One cycle. FIFO reset = rst | (state==FLUSH).
    - Clears flush_pend; go to IDLE.
- **flush_pend**
  - Set when flush is sampled outside IDLE.
  - Flush never aborts a SEND in progress; tx_valid is held until tx_ready.
- **en**
  - en=0 blocks new pops only. A SEND in progress completes.
  - Writes are still accepted while en=0.
- **Full/empty**
  - Writes are never attempted when full; the ready gating guarantees this.
  - Pops happen only when !empty.
  - Simultaneous write and pop in the same cycle is legal; occupancy is unchanged.
- **tx_valid** must not drop before tx_ready, except on rst.

## Timing

- Reset values: state=IDLE, tx_valid=0, a_ready=b_ready=0, busy=0, prio=A, flush_pend=0, FIFO empty, tx_data=0.
- Latency (write accepted in cycle 0):
  - FIFO non-empty in cycle 1; rd_en in cycle 1.
  - tx_valid with the byte in cycle 2, provided en=1 and state=IDLE.
- Throughput: at most one byte per 2 cycles, because SEND→IDLE→SEND.
- The FIFO accepts up to DEPTH queued bytes, plus one byte held in SEND.
- Flush sampled in IDLE:
  - FLUSH next cycle; FIFO empty the cycle after.
  - Producers are blocked for 2 cycles.
- Flush sampled in SEND: producers are blocked until the FLUSH cycle completes.
- rst mid-SEND: tx_valid=0 in the following cycle; queued data is lost.

## Structure

- **Package uart_pkg:**
  - typedef enum logic [1:0] tx_sched_state_t {IDLE, SEND, FLUSH}
  - typedef enum logic prio_t {PRIO_A, PRIO_B}
- **Sub-module:** one fifo_sync instance, with WIDTH/DEPTH/ADDR_BITS passed through.
  - Its rst is tied to rst | (state==FLUSH).
- Arbiter and FSM are written inline; no further hierarchy.

## Test plan

- **Single byte:** A writes 0x41 with tx_ready=1 → a_ready=1 in cycle 0; tx_valid=1 with tx_data=0x41 in cycle 2, for exactly one cycle; busy returns to 0 afterwards.
- **Contention:** A streams 0x10,0x11,… and B streams 0x20,0x21,… continuously, tx_ready=0 → 5 bytes accepted (4 in FIFO, 1 in SEND). Then a_ready=b_ready=0. Releasing tx_ready emits 0x10,0x20,0x11,0x21,0x12 in order.
- **Flush during SEND:** SEND holding 0x55, 3 bytes queued, flush pulse, tx_ready raised 3 cycles later → 0x55 is delivered and FLUSH follows. No further tx_valid; producers blocked until FLUSH ends.
- **Drain gating:** en=0 while A writes 0x01,0x02,0x03 → no tx_valid. Setting en=1 with tx_ready=1 → 0x01,0x02,0x03 delivered, each 2 cycles apart.
- **Reset mid-operation:** rst asserted during SEND with 2 bytes queued → tx_valid=0, busy=0, prio=A. A subsequent B write of 0x7E is delivered first, 2 cycles later.
- **Full boundary:** FIFO full, tx_ready pulsed for one cycle while A is valid → exactly one pop. A is accepted one cycle later, and occupancy returns to DEPTH.
